mem_access_ctl: RTL and testbench
=================================

// Module: mem_access_ctl
// PURPOSE
// - Sequences data-memory accesses for the MEM/WB stage of the PLP core. Accepts one
//   load/store request, runs the word-wide memory-bus handshake, and stalls the pipeline
//   until the access completes.
// - Supplies the writeback mux with the latched read word (data_word) and byte lane (lbu_byte).
// - Store-byte runs as read-modify-write, because the bus has no byte enables.
// PARAMETERS
// - W_DATA       32  data/address width (`W_DATA); byte merge logic is fixed at 32 bits
// - TIMEOUT_CYC  64  bus cycles without ack before abort (used only with BUS_TIMEOUT_EN)
// PORTS
// - clk        in   1       core clock, rising edge
// - rst        in   1       asynchronous, active-high reset
// - req_valid  in   1       access request; held stable with req_* while stall=1
// - req_op     in   2       0=LW 1=LBU 2=SW 3=SB
// - req_addr   in   W_DATA  byte address
// - req_wdata  in   W_DATA  store data; SB uses [7:0]
// - stall      out  1       freeze upstream pipeline
// - ld_done    out  1       one-cycle pulse: access finished, data_word valid
// - data_word  out  W_DATA  last word read from bus (feeds wb data_word)
// - lbu_byte   out  2       latched req_addr[1:0] (feeds wb lbu_byte)
// - bus_req    out  1       bus cycle request, registered
// - bus_we     out  1       1=write, registered
// - bus_addr   out  W_DATA  {addr[31:2],2'b00}, registered
// - bus_wdata  out  W_DATA  write word, registered
// - bus_ack    in   1       completes the current bus cycle; rdata valid with it
// - bus_rdata  in   W_DATA  read data
// - bus_err    out  1       timeout abort flag (tied 0 without BUS_TIMEOUT_EN)
// BEHAVIOUR
// - Reset (async): state=IDLE.
//   - All registered outputs 0: bus_req, bus_we, bus_addr, bus_wdata, data_word,
//     lbu_byte, ld_done, bus_err.
//   - An access in flight is dropped; bus_req falls immediately. No write is retried.
// - States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
// - IDLE:
//   - On req_valid: latch op, addr, wdata and lbu_byte<=addr[1:0].
//   - Next state: LW/LBU->RD, SW->WR, SB->RMW_RD.
//   - At the same edge load bus_addr (aligned) and bus_we, and set bus_req=1.
// - RD / RMW_RD (bus_req=1, bus_we=0):
//   - On bus_ack: data_word<=bus_rdata.
//   - RD->DONE.
//   - RMW_RD->RMW_WR: bus_wdata <= rdata with lane addr[1:0] replaced by wdata[7:0]
//     (lane0=[7:0] ... lane3=[31:24]); bus_we=1.
// - WR / RMW_WR (bus_req=1, bus_we=1): on bus_ack -> DONE; bus_req<=0.
//   - SW writes req_wdata unchanged.
// - DONE: ld_done=1, bus_req=0 -> IDLE.
//   - req_valid is ignored in DONE; the next request is accepted in the following IDLE cycle.
// - stall (combinational) = (IDLE & req_valid) | state in {RD,WR,RMW_RD,RMW_WR}; 0 in DONE.
// - Latency with zero-wait ack: LW/LBU/SW = 3 cycles (accept, bus, DONE); SB = 4.
//   - Each wait cycle (no ack) adds 1.
// - bus_req stays high, with addr/we/wdata unchanged, until bus_ack is sampled.
//   - bus_ack outside RD/WR/RMW_* is ignored.
// - LW/SW with addr[1:0]!=0: aligned word access, low bits ignored.
//   - lbu_byte still latches them; they are meaningful only for LBU/SB.
// - data_word holds its value across stores and until the next read completes.
//   - SB updates data_word with the pre-merge read word.
// - ld_done pulses for stores too; the writeback select ignores it for stores.
// CONFIGURATION
// - Macro BUS_TIMEOUT_EN:
//   - Defined: a counter clears on entry to any bus state and increments each cycle
//     bus_req=1 & !bus_ack.
//     - At TIMEOUT_CYC: bus_req<=0, go to DONE, bus_err=1 for the DONE cycle only;
//       data_word is unchanged.
//     - On RMW_RD timeout the write phase is skipped.
//   - Undefined: no counter; the FSM waits indefinitely for ack and bus_err=0 constant.
// TESTING
// 1. LW addr=0x100, ack in 1st bus cycle, rdata=0xCAFEF00D
//    -> bus_addr=0x100, stall 2 cycles, ld_done in cycle 3, data_word=0xCAFEF00D.
// 2. LBU addr=0x103, ack after 3 waits, rdata=0x11223344
//    -> lbu_byte=3, stall 5 cycles, data_word=0x11223344.
// 3. SB addr=0x202, wdata=0xAB, read returns 0x11223344
//    -> write cycle bus_we=1, bus_wdata=0x11AB3344, bus_addr=0x200, ld_done at cycle 4.
// 4. Back-to-back SW 0x10 then LW 0x14, req_valid held high
//    -> second access accepted the cycle after DONE; no duplicate SW.
// 5. rst asserted while bus_req=1 in WR
//    -> bus_req=0 at once, state IDLE, all outputs 0; a new LW is accepted after rst release.
// 6. BUS_TIMEOUT_EN, TIMEOUT_CYC=4, no ack on LW
//    -> bus_req drops after 4 cycles, bus_err=1 and ld_done=1 for one cycle, data_word unchanged.

Source files
------------

// File: rtl/mem_access_ctl.sv
// MEM/WB data-memory access sequencer: one load/store per request, word-wide bus handshake,
// store-byte as read-modify-write. Optional bus timeout abort under `BUS_TIMEOUT_EN.
module mem_access_ctl #(
  parameter int unsigned W_DATA      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [W_DATA-1:0] req_addr,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              stall,
  output logic              ld_done,
  output logic [W_DATA-1:0] data_word,
  output logic [1:0]        lbu_byte,
  output logic              bus_req,
  output logic              bus_we,
  output logic [W_DATA-1:0] bus_addr,
  output logic [W_DATA-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [W_DATA-1:0] bus_rdata,
  output logic              bus_err
);

  localparam logic [1:0] OpLw  = 2'd0;
  localparam logic [1:0] OpLbu = 2'd1;
  localparam logic [1:0] OpSw  = 2'd2;
  localparam logic [1:0] OpSb  = 2'd3;

  typedef enum logic [2:0] {StIdle, StRd, StWr, StRmwRd, StRmwWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sb_byte_q;
  logic [W_DATA-1:0] rmw_word;
  logic              in_bus;
  logic              accept;
  logic              tmo_hit;

  assign in_bus = (state_q == StRd) || (state_q == StWr) ||
                  (state_q == StRmwRd) || (state_q == StRmwWr);
  assign accept = (state_q == StIdle) && req_valid;
  assign stall  = accept || in_bus;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q;

  assign tmo_hit = in_bus && bus_req && !bus_ack && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  // Cleared on entry to each bus phase, so the RMW write phase gets its own budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= tmo_hit;
      if (accept || ((state_q == StRmwRd) && bus_ack)) begin
        tmo_cnt_q <= '0;
      end else if (in_bus && bus_req && !bus_ack) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          unique case (req_op)
            OpLw, OpLbu: state_d = StRd;
            OpSw:        state_d = StWr;
            OpSb:        state_d = StRmwRd;
            default:     state_d = StIdle;
          endcase
        end
      end
      StRd, StWr, StRmwWr: begin
        if (bus_ack || tmo_hit) state_d = StDone;
      end
      StRmwRd: begin
        if (bus_ack) begin
          state_d = StRmwWr;
        end else if (tmo_hit) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Replace the addressed byte lane of the read word with the store byte.
  always_comb begin
    rmw_word = bus_rdata;
    rmw_word[{lbu_byte, 3'b000} +: 8] = sb_byte_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      data_word <= '0;
      lbu_byte  <= 2'b00;
      sb_byte_q <= 8'h00;
      ld_done   <= 1'b0;
    end else begin
      ld_done <= (state_d == StDone);
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            lbu_byte  <= req_addr[1:0];
            sb_byte_q <= req_wdata[7:0];
            bus_addr  <= {req_addr[W_DATA-1:2], 2'b00};
            bus_we    <= (req_op == OpSw);
            bus_req   <= 1'b1;
            if (req_op == OpSw) bus_wdata <= req_wdata;
          end
        end
        StRd: begin
          if (bus_ack) begin
            data_word <= bus_rdata;
            bus_req   <= 1'b0;
          end else if (tmo_hit) begin
            bus_req <= 1'b0;
          end
        end
        StRmwRd: begin
          if (bus_ack) begin
            data_word <= bus_rdata;
            bus_wdata <= rmw_word;
            bus_we    <= 1'b1;
          end else if (tmo_hit) begin
            bus_req <= 1'b0;
          end
        end
        StWr, StRmwWr: begin
          if (bus_ack || tmo_hit) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Directed-vector bench for mem_access_ctl; timeout scenario runs only with BUS_TIMEOUT_EN.
module tb_mem_access_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        ld_done;
  logic [31:0] data_word;
  logic [1:0]  lbu_byte;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int vectors    = 0;
  int miscompares = 0;
  int stall_cnt;
  int req_cnt;

  mem_access_ctl #(
    .W_DATA     (32),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .stall    (stall),
    .ld_done  (ld_done),
    .data_word(data_word),
    .lbu_byte (lbu_byte),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after the rising edge; callers drive inputs, then wait 1 ns and check.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rd);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    bus_ack   = ack;
    bus_rdata = rd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_data_word", data_word, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_bus_err", bus_err, 0);

    // LW 0x100, zero-wait ack
    tick(); drive(1'b1, 2'd0, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("lw_accept_stall", stall, 1);
    tick(); drive(1'b1, 2'd0, 32'h100, 32'h0, 1'b1, 32'hCAFEF00D);
    chk("lw_bus_req", bus_req, 1);
    chk("lw_bus_addr", bus_addr, 32'h100);
    chk("lw_bus_we", bus_we, 0);
    chk("lw_bus_stall", stall, 1);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("lw_done_pulse", ld_done, 1);
    chk("lw_done_stall", stall, 0);
    chk("lw_done_bus_req", bus_req, 0);
    chk("lw_data_word", data_word, 32'hCAFEF00D);
    // Stray ack in IDLE must be ignored
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h99999999);
    chk("lw_pulse_one_cycle", ld_done, 0);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("idle_ack_ignored_req", bus_req, 0);
    chk("idle_ack_ignored_data", data_word, 32'hCAFEF00D);

    // LBU 0x103, three wait cycles then ack
    stall_cnt = 0;
    tick(); drive(1'b1, 2'd1, 32'h103, 32'h0, 1'b0, 32'h0);
    stall_cnt += int'(stall);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, 2'd1, 32'h103, 32'h0, 1'b0, 32'h0);
      stall_cnt += int'(stall);
      chk("lbu_wait_bus_req", bus_req, 1);
    end
    tick(); drive(1'b1, 2'd1, 32'h103, 32'h0, 1'b1, 32'h11223344);
    stall_cnt += int'(stall);
    chk("lbu_bus_addr", bus_addr, 32'h100);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    stall_cnt += int'(stall);
    chk("lbu_stall_cycles", stall_cnt, 5);
    chk("lbu_lbu_byte", lbu_byte, 3);
    chk("lbu_ld_done", ld_done, 1);
    chk("lbu_data_word", data_word, 32'h11223344);

    // SB 0x202, byte 0xAB merged into lane 2
    tick(); drive(1'b1, 2'd3, 32'h202, 32'hFFFFFFAB, 1'b0, 32'h0);
    chk("sb_accept_stall", stall, 1);
    tick(); drive(1'b1, 2'd3, 32'h202, 32'hFFFFFFAB, 1'b1, 32'h11223344);
    chk("sb_rd_we", bus_we, 0);
    chk("sb_rd_addr", bus_addr, 32'h200);
    tick(); drive(1'b1, 2'd3, 32'h202, 32'hFFFFFFAB, 1'b1, 32'h0);
    chk("sb_wr_req", bus_req, 1);
    chk("sb_wr_we", bus_we, 1);
    chk("sb_wr_wdata", bus_wdata, 32'h11AB3344);
    chk("sb_wr_addr", bus_addr, 32'h200);
    chk("sb_wr_stall", stall, 1);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("sb_ld_done_c4", ld_done, 1);
    chk("sb_data_word_premerge", data_word, 32'h11223344);

    // Back-to-back SW 0x10 then LW 0x14 with req_valid held high
    req_cnt = 0;
    tick(); drive(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    tick(); drive(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0);
    chk("sw_we", bus_we, 1);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    chk("sw_addr", bus_addr, 32'h10);
    tick(); drive(1'b1, 2'd0, 32'h14, 32'h0, 1'b0, 32'h0);
    chk("sw_ld_done", ld_done, 1);
    chk("sw_done_stall", stall, 0);
    chk("sw_data_word_held", data_word, 32'h11223344);
    tick(); drive(1'b1, 2'd0, 32'h14, 32'h0, 1'b0, 32'h0);
    chk("b2b_idle_no_req", bus_req, 0);
    chk("b2b_idle_stall", stall, 1);
    tick(); drive(1'b1, 2'd0, 32'h14, 32'h0, 1'b1, 32'h55AA55AA);
    chk("b2b_lw_addr", bus_addr, 32'h14);
    chk("b2b_lw_we", bus_we, 0);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("b2b_lw_data", data_word, 32'h55AA55AA);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("b2b_quiet", bus_req, 0);

    // Reset while a write is in flight
    tick(); drive(1'b1, 2'd2, 32'h40, 32'h12345678, 1'b0, 32'h0);
    tick(); drive(1'b1, 2'd2, 32'h40, 32'h12345678, 1'b0, 32'h0);
    chk("rstwr_bus_req", bus_req, 1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rstwr_req_drop", bus_req, 0);
    chk("rstwr_we", bus_we, 0);
    chk("rstwr_addr", bus_addr, 0);
    chk("rstwr_wdata", bus_wdata, 0);
    chk("rstwr_data_word", data_word, 0);
    chk("rstwr_lbu_byte", lbu_byte, 0);
    chk("rstwr_stall", stall, 0);
    #3;
    rst = 1'b0;
    tick(); drive(1'b1, 2'd0, 32'h80, 32'h0, 1'b0, 32'h0);
    chk("rstwr_no_retry", bus_req, 0);
    tick(); drive(1'b1, 2'd0, 32'h80, 32'h0, 1'b1, 32'h0BADF00D);
    chk("post_rst_lw_addr", bus_addr, 32'h80);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("post_rst_lw_done", ld_done, 1);
    chk("post_rst_lw_data", data_word, 32'h0BADF00D);

`ifdef BUS_TIMEOUT_EN
    // LW with no ack; abort after four bus cycles
    tick(); drive(1'b1, 2'd0, 32'h300, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b1, 2'd0, 32'h300, 32'h0, 1'b0, 32'h0);
      req_cnt += int'(bus_req);
    end
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("tmo_req_cycles", req_cnt, 4);
    chk("tmo_req_drop", bus_req, 0);
    chk("tmo_err", bus_err, 1);
    chk("tmo_ld_done", ld_done, 1);
    chk("tmo_data_held", data_word, 32'h0BADF00D);
    tick(); drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("tmo_err_one_cycle", bus_err, 0);
`else
    chk("no_tmo_err_tied", bus_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
